bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: Bus_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: order-FIFO depth (max issued commands awaiting response); power of two, >= 2.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in0  Bus_if.slave  interface  master port 0; higher priority on first tie after reset.
REQ-005 in1  Bus_if.slave  interface  master port 1.
REQ-006 out  Bus_if.master  interface  merged port; feeds one downstream bus stage or slave.
REQ-007 stat_grants0, stat_grants1  output  32 each  accepted-command counters; present only with BUS_ARBITER_STATS_EN.

Function
REQ-008 A port requests when its MCmd != Bus::IDLE.
REQ-009 FSM states: S_ARB (no pending command) and S_LOCK (command presented on out, not yet accepted).
REQ-010 In S_ARB, one requester is granted; if both request, grant the port other than last_grant (round robin).
REQ-011 Granted port's MCmd/MAddr/MData/MByteEn drive out combinationally in the same cycle; zero added request latency.
REQ-012 S_ARB -> S_LOCK when a grant is issued and out.SCmdAccept=0; the grant is then frozen until acceptance.
REQ-013 S_LOCK -> S_ARB on out.SCmdAccept=1; a grant accepted in its first cycle stays in S_ARB.
REQ-014 SCmdAccept of the granted port = out.SCmdAccept; the non-granted port's SCmdAccept = 0.
REQ-015 No grant: out.MCmd = Bus::IDLE; out.MAddr/MData/MByteEn = 0.
REQ-016 On each accepted command: push granted id into order FIFO; set last_grant = granted id.
REQ-017 Every accepted command produces exactly one response (out.SResp != Bus::NULL).
REQ-018 Order FIFO full: no new grant (out.MCmd = IDLE, both SCmdAccept = 0); a command already in S_LOCK stays presented.
REQ-019 Full with simultaneous pop: push still blocked that cycle; arbitration resumes next cycle.
REQ-020 Responses route to the FIFO-head id: that port sees out.SResp/SData; the other port sees SResp = Bus::NULL.
REQ-021 out.MRespAccept = MRespAccept of the head port; pop when out.SResp != NULL && out.MRespAccept.
REQ-022 Same-cycle push and pop (FIFO not full): occupancy unchanged; both pointers advance, wrapping modulo MAX_OUTSTANDING.
REQ-023 Response while FIFO empty is a protocol error: both ports see SResp = NULL; out.MRespAccept = 0; simulation assertion fires.
REQ-024 out.MReset_n = ~reset.

Reset
REQ-025 Synchronous reset forces: state = S_ARB, last_grant = 1, FIFO empty with pointers 0, stat counters 0.
REQ-026 During reset, out.MCmd = IDLE, both SCmdAccept = 0, both SResp = NULL.
REQ-027 Reset mid-transaction discards all outstanding order entries; no response is routed after reset.

Configuration
REQ-028 Macro BUS_ARBITER_STATS_EN:
  - Defined: stat_grants0/1 exist; each increments by 1 per accepted command on its port and wraps at 2^32.
  - Undefined: ports and counters are absent; all other behaviour is identical.

Structure
REQ-029 Package Bus holds Ocp_cmd, Ocp_resp, and a new Master_id typedef (logic[0:0]); the arbiter defines no local copies.
REQ-030 The order FIFO is a sub-module Arb_order_fifo (params WIDTH, DEPTH; ports push, pop, data_in, data_out, full, empty).
REQ-031 Assertions: no push while full; no pop while empty; grant stable in S_LOCK. All assertions are under `ifndef SYNTHESIS.

Verification
REQ-032 Only in0 issues WR addr 0x10 with accept=1 -> out.MAddr = 0x10 in the same cycle; FIFO holds id 0; DVA response is routed to in0 only.
REQ-033 Both ports request every cycle, accept=1, 6 cycles after reset -> grant order 0,1,0,1,0,1.
REQ-034 in1 granted, accept held 0 for 3 cycles while in0 also requests -> out carries in1's command unchanged for 4 cycles; in0 is granted next.
REQ-035 MAX_OUTSTANDING=4, 4 accepted commands, no responses -> 5th request sees SCmdAccept=0 and out.MCmd=IDLE; one response popped -> grant issued the next cycle.
REQ-036 Issue in0, in1, in0 and return 3 responses with SData 0xA, 0xB, 0xC -> in0 receives 0xA then 0xC, in1 receives 0xB; in0's MRespAccept=0 stalls out.MRespAccept.
REQ-037 reset asserted with 2 outstanding, then a stray response -> both ports see SResp=NULL and the assertion fires; with STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus types for the arbiter slice.
// Package Bus: OCP-style command/response encodings, bus field widths and the
// 1-bit Master_id that tags which arbiter input issued a command.
package Bus;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2
    } Ocp_cmd;

    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        ERR  = 2'd3
    } Ocp_resp;

    typedef logic [0:0] Master_id;
endpackage

// File: rtl/bus_if.sv
// Bus_if: one OCP-style bus link.
// master modport drives the request side (MCmd/MAddr/MData/MByteEn),
// MRespAccept and MReset_n; slave modport returns SCmdAccept/SResp/SData.
interface Bus_if;
    import Bus::*;

    Ocp_cmd              MCmd;
    logic [ADDR_W-1:0]   MAddr;
    logic [DATA_W-1:0]   MData;
    logic [BE_W-1:0]     MByteEn;
    logic                MRespAccept;
    logic                MReset_n;
    logic                SCmdAccept;
    Ocp_resp             SResp;
    logic [DATA_W-1:0]   SData;

    modport master (
        output MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
        input  SCmdAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MByteEn, MRespAccept,
        output SCmdAccept, SResp, SData
    );
endinterface

// File: rtl/bus_arbiter_order_fifo.sv
// Arb_order_fifo: small FIFO remembering which master owns each outstanding
// command, so responses can be routed back in issue order.
// Ports: clk, reset (sync, active-high), push/data_in (write side),
// pop/data_out (read side, data_out shows the head), full, empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module Arb_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // A push against a full FIFO is dropped even if a pop happens that cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full))  else $error("order fifo: push while full");
            assert (!(pop && empty))  else $error("order fifo: pop while empty");
        end
    end
`endif
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: merges two Bus_if masters onto one downstream port.
// Ports: clk, reset (sync, active-high); in0/in1 (Bus_if.slave, masters);
// out (Bus_if.master, merged port); stat_grants0/1 (32-bit accepted-command
// counters) only when BUS_ARBITER_STATS_EN is defined.
// Arbitration is round robin against last_grant; a grant not accepted in its
// first cycle is frozen (S_LOCK) until accepted. An order FIFO of master ids
// routes responses back in issue order.
module bus_arbiter
    import Bus::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic  clk,
    input  logic  reset,
    Bus_if.slave  in0,
    Bus_if.slave  in1,
    Bus_if.master out
`ifdef BUS_ARBITER_STATS_EN
    ,
    output logic [31:0] stat_grants0,
    output logic [31:0] stat_grants1
`endif
);
    typedef enum logic {S_ARB, S_LOCK} arb_state_t;

    arb_state_t state, state_nxt;
    Master_id   last_grant, lock_id, gnt_id, head_id;
    logic       req0, req1, gnt_vld, cmd_acc;
    logic       push, pop, fifo_full, fifo_empty, rsp_live;

    assign req0 = (in0.MCmd != Bus::IDLE);
    assign req1 = (in1.MCmd != Bus::IDLE);
    assign out.MReset_n = ~reset;

    // Grant selection and FSM next state. A full order FIFO blocks new grants
    // only; a locked command keeps being presented.
    always_comb begin
        state_nxt = state;
        gnt_vld   = 1'b0;
        gnt_id    = lock_id;
        if (!reset) begin
            if (state == S_LOCK) begin
                gnt_vld = 1'b1;
            end else if (!fifo_full) begin
                if (req0 && req1) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ~last_grant;
                end else if (req0) begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end else if (req1) begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
            end
        end
        cmd_acc = gnt_vld && out.SCmdAccept && !fifo_full;
        if (cmd_acc)      state_nxt = S_ARB;
        else if (gnt_vld) state_nxt = S_LOCK;
    end

    assign push = cmd_acc;

    // Request path: granted master drives out with no added latency.
    always_comb begin
        out.MCmd        = Bus::IDLE;
        out.MAddr       = '0;
        out.MData       = '0;
        out.MByteEn     = '0;
        in0.SCmdAccept  = 1'b0;
        in1.SCmdAccept  = 1'b0;
        if (gnt_vld) begin
            if (gnt_id == 1'b0) begin
                out.MCmd       = in0.MCmd;
                out.MAddr      = in0.MAddr;
                out.MData      = in0.MData;
                out.MByteEn    = in0.MByteEn;
                in0.SCmdAccept = cmd_acc;
            end else begin
                out.MCmd       = in1.MCmd;
                out.MAddr      = in1.MAddr;
                out.MData      = in1.MData;
                out.MByteEn    = in1.MByteEn;
                in1.SCmdAccept = cmd_acc;
            end
        end
    end

    // Response path: only the FIFO-head master sees the response. With the
    // FIFO empty (or in reset) nothing is routed and nothing is accepted.
    assign rsp_live = !reset && !fifo_empty;
    assign pop      = rsp_live && (out.SResp != Bus::NULL) && out.MRespAccept;

    always_comb begin
        in0.SResp       = Bus::NULL;
        in0.SData       = '0;
        in1.SResp       = Bus::NULL;
        in1.SData       = '0;
        out.MRespAccept = 1'b0;
        if (rsp_live) begin
            if (head_id == 1'b0) begin
                in0.SResp       = out.SResp;
                in0.SData       = out.SData;
                out.MRespAccept = in0.MRespAccept;
            end else begin
                in1.SResp       = out.SResp;
                in1.SData       = out.SData;
                out.MRespAccept = in1.MRespAccept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ARB;
            last_grant <= 1'b1;
            lock_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt_vld) lock_id    <= gnt_id;
            if (cmd_acc) last_grant <= gnt_id;
        end
    end

    Arb_order_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (gnt_id),
        .data_out (head_id),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef BUS_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants0 <= '0;
            stat_grants1 <= '0;
        end else if (cmd_acc) begin
            if (gnt_id == 1'b0) stat_grants0 <= stat_grants0 + 32'd1;
            else                stat_grants1 <= stat_grants1 + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    Master_id lock_id_q;
    logic     in_lock_q;

    always_ff @(posedge clk) begin
        lock_id_q <= lock_id;
        in_lock_q <= !reset && (state == S_LOCK);
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(in_lock_q && state == S_LOCK) || lock_id == lock_id_q)
                else $error("bus_arbiter: grant changed while locked");
            assert (!(fifo_empty && out.SResp != Bus::NULL))
                else $error("bus_arbiter: response with no outstanding command");
        end
    end
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grants and responses are predicted by a
// small order-queue model; expectations are queued when stimulus is driven
// and compared when the DUT output is sampled on the falling edge.
module tb_bus_arbiter;
    import Bus::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    Bus_if in0_if ();
    Bus_if in1_if ();
    Bus_if out_if ();

`ifdef BUS_ARBITER_STATS_EN
    logic [31:0] stat0, stat1;
`endif

    bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0_if),
        .in1   (in1_if),
        .out   (out_if)
`ifdef BUS_ARBITER_STATS_EN
        ,
        .stat_grants0 (stat0),
        .stat_grants1 (stat1)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          ord_q[$];
    int          exp_gnt_q[$];
    int          exp_rcv_q[$];
    logic [31:0] exp_dat_q[$];
    int          cnt0 = 0;
    int          cnt1 = 0;
    logic        mra0 = 1'b1;
    logic        mra1 = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive requests/accept/response, check at negedge, then
    // advance the order model the way the arbiter should have.
    task automatic cycle(input string tag, input logic r0, input logic r1, input logic acc,
                         input int exp_gnt, input logic rsp, input logic [31:0] rdata);
        int          g;
        int          rcv;
        logic [31:0] d;
        logic        rmra;
        rcv  = -1;
        rmra = 1'b0;
        in0_if.MCmd        = r0 ? WR : IDLE;
        in1_if.MCmd        = r1 ? RD : IDLE;
        in0_if.MRespAccept = mra0;
        in1_if.MRespAccept = mra1;
        out_if.SCmdAccept  = acc;
        out_if.SResp       = rsp ? DVA : NULL;
        out_if.SData       = rdata;
        exp_gnt_q.push_back(exp_gnt);
        if (rsp) begin
            exp_rcv_q.push_back((ord_q.size() > 0) ? ord_q[0] : -1);
            exp_dat_q.push_back(rdata);
        end
        @(negedge clk);
        g = exp_gnt_q.pop_front();
        if (g < 0) begin
            check({tag, "_mcmd"}, 32'(out_if.MCmd), 32'(IDLE));
            check({tag, "_acc0"}, 32'(in0_if.SCmdAccept), 32'd0);
            check({tag, "_acc1"}, 32'(in1_if.SCmdAccept), 32'd0);
        end else begin
            check({tag, "_mcmd"},  32'(out_if.MCmd), (g == 1) ? 32'(RD) : 32'(WR));
            check({tag, "_maddr"}, out_if.MAddr, (g == 1) ? 32'h20 : 32'h10);
            check({tag, "_acc0"},  32'(in0_if.SCmdAccept), 32'((g == 0) ? acc : 1'b0));
            check({tag, "_acc1"},  32'(in1_if.SCmdAccept), 32'((g == 1) ? acc : 1'b0));
        end
        if (rsp) begin
            rcv  = exp_rcv_q.pop_front();
            d    = exp_dat_q.pop_front();
            rmra = (rcv == 0) ? mra0 : (rcv == 1) ? mra1 : 1'b0;
            check({tag, "_sresp0"}, 32'(in0_if.SResp), (rcv == 0) ? 32'(DVA) : 32'(NULL));
            check({tag, "_sresp1"}, 32'(in1_if.SResp), (rcv == 1) ? 32'(DVA) : 32'(NULL));
            if (rcv == 0) check({tag, "_sdata0"}, in0_if.SData, d);
            if (rcv == 1) check({tag, "_sdata1"}, in1_if.SData, d);
            check({tag, "_mra"}, 32'(out_if.MRespAccept), 32'(rmra));
        end
        @(posedge clk);
        #1;
        if (rsp && rcv >= 0 && rmra) void'(ord_q.pop_front());
        if (g >= 0 && acc) begin
            ord_q.push_back(g);
            if (g == 0) cnt0++;
            else        cnt1++;
        end
    endtask

    // Reset with busy-looking inputs; outputs must be quiet during reset and
    // no response may be accepted afterwards.
    task automatic do_reset(input string tag);
        reset              = 1'b1;
        in0_if.MCmd        = WR;
        in1_if.MCmd        = RD;
        in0_if.MRespAccept = 1'b1;
        in1_if.MRespAccept = 1'b1;
        out_if.SCmdAccept  = 1'b1;
        out_if.SResp       = DVA;
        out_if.SData       = 32'hDEAD;
        @(negedge clk);
        check({tag, "_mcmd"},   32'(out_if.MCmd), 32'(IDLE));
        check({tag, "_acc0"},   32'(in0_if.SCmdAccept), 32'd0);
        check({tag, "_acc1"},   32'(in1_if.SCmdAccept), 32'd0);
        check({tag, "_sresp0"}, 32'(in0_if.SResp), 32'(NULL));
        check({tag, "_sresp1"}, 32'(in1_if.SResp), 32'(NULL));
        check({tag, "_mrst"},   32'(out_if.MReset_n), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset             = 1'b0;
        in0_if.MCmd       = IDLE;
        in1_if.MCmd       = IDLE;
        out_if.SCmdAccept = 1'b0;
        out_if.SResp      = NULL;
        out_if.SData      = '0;
        mra0              = 1'b1;
        mra1              = 1'b1;
        ord_q.delete();
        cnt0 = 0;
        cnt1 = 0;
        @(negedge clk);
        check({tag, "_mrst_hi"}, 32'(out_if.MReset_n), 32'd1);
        check({tag, "_mra_flush"}, 32'(out_if.MRespAccept), 32'd0);
`ifdef BUS_ARBITER_STATS_EN
        check({tag, "_stat0"}, stat0, 32'd0);
        check({tag, "_stat1"}, stat1, 32'd0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in0_if.MAddr    = 32'h10;
        in0_if.MData    = 32'h100;
        in0_if.MByteEn  = 4'hF;
        in0_if.MReset_n = 1'b1;
        in1_if.MAddr    = 32'h20;
        in1_if.MData    = 32'h200;
        in1_if.MByteEn  = 4'h3;
        in1_if.MReset_n = 1'b1;

        do_reset("rst_a");

        // Single in0 write, then its DVA response routed to in0 only.
        cycle("a_wr",  1'b1, 1'b0, 1'b1,  0, 1'b0, 32'h0);
        cycle("a_rsp", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hA5);

        // Round robin from reset with both requesting every cycle.
        do_reset("rst_b");
        cycle("b_g1", 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h0);
        cycle("b_g2", 1'b1, 1'b1, 1'b1, 1, 1'b1, 32'hB1);
        cycle("b_g3", 1'b1, 1'b1, 1'b1, 0, 1'b1, 32'hB2);
        cycle("b_g4", 1'b1, 1'b1, 1'b1, 1, 1'b1, 32'hB3);
        cycle("b_g5", 1'b1, 1'b1, 1'b1, 0, 1'b1, 32'hB4);
        cycle("b_g6", 1'b1, 1'b1, 1'b1, 1, 1'b1, 32'hB5);
        cycle("b_drn", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hB6);

        // in1 granted and held locked for three unaccepted cycles.
        cycle("c_g0",   1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h0);
        cycle("c_lk1",  1'b1, 1'b1, 1'b0, 1, 1'b0, 32'h0);
        cycle("c_lk2",  1'b1, 1'b1, 1'b0, 1, 1'b0, 32'h0);
        cycle("c_lk3",  1'b1, 1'b1, 1'b0, 1, 1'b0, 32'h0);
        cycle("c_acc",  1'b1, 1'b1, 1'b1, 1, 1'b0, 32'h0);
        cycle("c_next", 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h0);

        // Ordered responses for in0, in1, in0 with a stall from in0.
        cycle("f_r1", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hA);
        cycle("f_r2", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hB);
        mra0 = 1'b0;
        cycle("f_stall", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hC);
        mra0 = 1'b1;
        cycle("f_r3", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hC);

        // Fill the order FIFO, see the next request blocked, pop, resume.
        cycle("d_i1", 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        cycle("d_i2", 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        cycle("d_i3", 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        cycle("d_i4", 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        cycle("d_full",    1'b1, 1'b0, 1'b1, -1, 1'b0, 32'h0);
        cycle("d_fullpop", 1'b1, 1'b0, 1'b1, -1, 1'b1, 32'hD0);
        cycle("d_resume",  1'b1, 1'b0, 1'b1,  0, 1'b0, 32'h0);
`ifdef BUS_ARBITER_STATS_EN
        check("d_stat0", stat0, 32'(cnt0));
        check("d_stat1", stat1, 32'(cnt1));
`endif
        cycle("d_drn1", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hD1);
        cycle("d_drn2", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hD2);

        // Reset with two commands outstanding: entries are discarded.
        do_reset("rst_e");
        cycle("e_rr",  1'b1, 1'b1, 1'b1,  0, 1'b0, 32'h0);
        cycle("e_rsp", 1'b0, 1'b0, 1'b0, -1, 1'b1, 32'hE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
